// File: rtl/layer_output_collector_pkg.sv
// Shared types and sizes for the output-layer collector.
// Sizes derive from the global network defines when present.
`ifndef numNeuronLayer4
`define numNeuronLayer4 10
`endif
`ifndef dataWidth
`define dataWidth 16
`endif

package layer_output_collector_pkg;

    localparam int NUM_NEURON = `numNeuronLayer4;
    localparam int DATA_WIDTH = `dataWidth;

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef word_t [NUM_NEURON-1:0] frame_t;

endpackage

// File: rtl/layer_output_collector_slot.sv
// One capture slot: a buffered neuron word plus its mask bit.
// Ports: clk_i/rst_i, valid_i/data_i strobe, clear_i on completion,
// captured_o (mask bit), word_o (buffered or live word),
// dup_strobe_o (strobe hit an already-captured slot).
module collector_slot
    import layer_output_collector_pkg::*;
#(
    parameter int W = DATA_WIDTH
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         valid_i,
    input  logic         clear_i,
    input  logic [W-1:0] data_i,
    output logic         captured_o,
    output logic [W-1:0] word_o,
    output logic         dup_strobe_o
);

    logic         captured_d, captured_q;
    logic [W-1:0] word_d, word_q;

    always_comb begin
        captured_d = captured_q;
        word_d     = word_q;
        if (clear_i) begin
            captured_d = 1'b0;
        end else if (valid_i && !captured_q) begin
            captured_d = 1'b1;
            word_d     = data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            captured_q <= 1'b0;
            word_q     <= '0;
        end else begin
            captured_q <= captured_d;
            word_q     <= word_d;
        end
    end

    // Uncaptured slot shows the live input so a completing
    // strobe lands in the output register without a buffer hop.
    assign word_o       = captured_q ? word_q : data_i;
    assign captured_o   = captured_q;
    assign dup_strobe_o = valid_i & captured_q;

endmodule

// File: rtl/layer_output_collector.sv
// Collects out-of-order neuron strobes into one packed frame and
// pulses o_data_valid when complete. Ports: i_clk, i_rst (sync high),
// i_neuron_data/i_neuron_valid in; o_data/o_data_valid result,
// o_busy (partial frame), o_overrun (sticky), o_frame_count.
module layer_output_collector
    import layer_output_collector_pkg::*;
#(
    parameter int numNeuron  = NUM_NEURON,
    parameter int dataWidth  = DATA_WIDTH,
    parameter int countWidth = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [numNeuron*dataWidth-1:0] i_neuron_data,
    input  logic [numNeuron-1:0]          i_neuron_valid,
    output logic [numNeuron*dataWidth-1:0] o_data,
    output logic                          o_data_valid,
    output logic                          o_busy,
    output logic                          o_overrun,
    output logic [countWidth-1:0]         o_frame_count
);

    logic [numNeuron-1:0]           mask;
    logic [numNeuron-1:0]           dup;
    logic [numNeuron*dataWidth-1:0] merged;
    logic                           complete;

    logic [numNeuron*dataWidth-1:0] data_d, data_q;
    logic                           valid_d, valid_q;
    logic                           ovr_d, ovr_q;
    logic [countWidth-1:0]          cnt_d, cnt_q;

    for (genvar n = 0; n < numNeuron; n++) begin : g_slot
        collector_slot #(.W(dataWidth)) u_slot (
            .clk_i        (i_clk),
            .rst_i        (i_rst),
            .valid_i      (i_neuron_valid[n]),
            .clear_i      (complete),
            .data_i       (i_neuron_data[n*dataWidth +: dataWidth]),
            .captured_o   (mask[n]),
            .word_o       (merged[n*dataWidth +: dataWidth]),
            .dup_strobe_o (dup[n])
        );
    end

    assign complete = &(mask | i_neuron_valid);

    always_comb begin
        data_d  = data_q;
        valid_d = complete;
        ovr_d   = ovr_q | (|dup);
        cnt_d   = cnt_q;
        if (complete) begin
            data_d = merged;
            cnt_d  = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_data        = data_q;
    assign o_data_valid  = valid_q;
    assign o_busy        = |mask;
    assign o_overrun     = ovr_q;
    assign o_frame_count = cnt_q;

endmodule

// File: tb/tb_layer_output_collector.sv
// Directed bench for layer_output_collector, with a second
// instance at countWidth=4 to observe counter wrap.
module tb_layer_output_collector;

    localparam int NN = 10;
    localparam int DW = 16;
    localparam int BW = NN * DW;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic [BW-1:0] i_neuron_data;
    logic [NN-1:0] i_neuron_valid;

    logic [BW-1:0] o_data, o_data4;
    logic          o_data_valid, o_data_valid4;
    logic          o_busy, o_busy4;
    logic          o_overrun, o_overrun4;
    logic [15:0]   o_frame_count;
    logic [3:0]    o_frame_count4;

    int nvec = 0;
    int nerr = 0;

    always #5 i_clk = ~i_clk;

    layer_output_collector #(
        .numNeuron(NN), .dataWidth(DW), .countWidth(16)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_neuron_data  (i_neuron_data),
        .i_neuron_valid (i_neuron_valid),
        .o_data         (o_data),
        .o_data_valid   (o_data_valid),
        .o_busy         (o_busy),
        .o_overrun      (o_overrun),
        .o_frame_count  (o_frame_count)
    );

    layer_output_collector #(
        .numNeuron(NN), .dataWidth(DW), .countWidth(4)
    ) dut4 (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_neuron_data  (i_neuron_data),
        .i_neuron_valid (i_neuron_valid),
        .o_data         (o_data4),
        .o_data_valid   (o_data_valid4),
        .o_busy         (o_busy4),
        .o_overrun      (o_overrun4),
        .o_frame_count  (o_frame_count4)
    );

    function automatic logic [BW-1:0] pk(input logic [15:0] base,
                                         input logic [15:0] stp);
        logic [BW-1:0] r;
        for (int n = 0; n < NN; n++) r[n*DW +: DW] = base + 16'(n) * stp;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [BW-1:0] obs,
                       input logic [BW-1:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_neuron_valid = '0;
        i_neuron_data  = '0;
    endtask

    logic [BW-1:0] exp_f;

    initial begin
        i_rst = 1'b1;
        idle();
        tick();
        tick();
        i_rst = 1'b0;
        chk("rst_data", o_data, '0);
        chk("rst_valid", BW'(o_data_valid), '0);
        chk("rst_busy", BW'(o_busy), '0);
        chk("rst_ovr", BW'(o_overrun), '0);
        chk("rst_cnt", BW'(o_frame_count), '0);

        // 1: all ten in one cycle
        i_neuron_valid = '1;
        i_neuron_data  = pk(16'd0, 16'd3);
        tick();
        idle();
        chk("t1_valid", BW'(o_data_valid), 1);
        chk("t1_data", o_data, pk(16'd0, 16'd3));
        chk("t1_cnt", BW'(o_frame_count), 1);
        chk("t1_busy", BW'(o_busy), 0);
        tick();
        chk("t1_valid_drop", BW'(o_data_valid), 0);
        chk("t1_hold", o_data, pk(16'd0, 16'd3));

        // 2: one strobe per cycle, neuron 9 down to 0
        for (int i = NN - 1; i >= 0; i--) begin
            i_neuron_valid = NN'(1) << i;
            i_neuron_data  = pk(16'h0200, 16'd1);
            tick();
            idle();
            if (i > 0) begin
                chk("t2_busy", BW'(o_busy), 1);
                chk("t2_nopulse", BW'(o_data_valid), 0);
            end
        end
        chk("t2_valid", BW'(o_data_valid), 1);
        chk("t2_data", o_data, pk(16'h0200, 16'd1));
        chk("t2_busy_end", BW'(o_busy), 0);
        chk("t2_cnt", BW'(o_frame_count), 2);
        tick();
        chk("t2_single", BW'(o_data_valid), 0);

        // 3: duplicate on neuron 4, first value wins
        i_neuron_valid = NN'(1) << 4;
        i_neuron_data  = '0;
        i_neuron_data[4*DW +: DW] = 16'h0011;
        tick();
        chk("t3_ovr0", BW'(o_overrun), 0);
        i_neuron_data[4*DW +: DW] = 16'h0022;
        tick();
        chk("t3_ovr1", BW'(o_overrun), 1);
        chk("t3_nopulse", BW'(o_data_valid), 0);
        i_neuron_valid = ~(NN'(1) << 4);
        i_neuron_data  = pk(16'h0300, 16'd1);
        tick();
        idle();
        exp_f = pk(16'h0300, 16'd1);
        exp_f[4*DW +: DW] = 16'h0011;
        chk("t3_valid", BW'(o_data_valid), 1);
        chk("t3_data", o_data, exp_f);
        tick();
        chk("t3_ovr_sticky", BW'(o_overrun), 1);
        chk("t3_single", BW'(o_data_valid), 0);

        // 4: back-to-back frames A then B
        i_neuron_valid = '1;
        i_neuron_data  = pk(16'h0400, 16'd1);
        tick();
        i_neuron_data  = pk(16'h0100, 16'd1);
        chk("t4_a_valid", BW'(o_data_valid), 1);
        chk("t4_a_data", o_data, pk(16'h0400, 16'd1));
        tick();
        idle();
        chk("t4_b_valid", BW'(o_data_valid), 1);
        chk("t4_b_data", o_data, pk(16'h0100, 16'd1));
        chk("t4_cnt", BW'(o_frame_count), 5);
        tick();
        chk("t4_b_hold", o_data, pk(16'h0100, 16'd1));
        chk("t4_drop", BW'(o_data_valid), 0);

        // duplicates in the completing cycle do not carry over
        i_neuron_valid = 10'h1FF;
        i_neuron_data  = pk(16'h0600, 16'd1);
        tick();
        i_neuron_valid = '1;
        i_neuron_data  = pk(16'h0700, 16'd1);
        tick();
        idle();
        exp_f = pk(16'h0600, 16'd1);
        exp_f[9*DW +: DW] = 16'h0709;
        chk("t4d_valid", BW'(o_data_valid), 1);
        chk("t4d_data", o_data, exp_f);
        chk("t4d_busy", BW'(o_busy), 0);
        tick();

        // 5: reset discards a partial frame
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        i_neuron_valid = 10'h01F;
        i_neuron_data  = pk(16'hAA00, 16'd1);
        tick();
        chk("t5_busy", BW'(o_busy), 1);
        i_rst = 1'b1;
        i_neuron_valid = 10'h3E0;
        tick();
        i_rst = 1'b0;
        idle();
        chk("t5_busy_rst", BW'(o_busy), 0);
        chk("t5_ovr_rst", BW'(o_overrun), 0);
        chk("t5_cnt_rst", BW'(o_frame_count), 0);
        tick();
        chk("t5_nopulse", BW'(o_data_valid), 0);
        i_neuron_valid = '1;
        i_neuron_data  = pk(16'h0500, 16'd1);
        tick();
        idle();
        chk("t5_valid", BW'(o_data_valid), 1);
        chk("t5_data", o_data, pk(16'h0500, 16'd1));
        chk("t5_cnt", BW'(o_frame_count), 1);
        chk("t5_ovr", BW'(o_overrun), 0);
        tick();
        chk("t5_single", BW'(o_data_valid), 0);

        // 6: counter wrap on the 4-bit instance
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            i_neuron_valid = '1;
            i_neuron_data  = pk(16'(i), 16'h0010);
            tick();
            idle();
            chk("t6_valid", BW'(o_data_valid4), 1);
            chk("t6_cnt4", BW'(o_frame_count4), BW'((i + 1) % 16));
            tick();
            chk("t6_drop", BW'(o_data_valid4), 0);
        end
        chk("t6_cnt16", BW'(o_frame_count), 16);
        chk("t6_data", o_data4, pk(16'd15, 16'h0010));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/layer_output_collector.md
Name: layer_output_collector

Overview:
- Sits between the last fully-connected layer and max_finder.
- Gathers per-neuron outputs, which arrive with independent single-cycle valids in any order, into one packed vector.
- When every neuron of the frame has reported, emits the vector with a single-cycle valid pulse. This pair drives max_finder's i_data/i_valid directly.
- Double-buffered, so the next frame can start capturing while the previous result is held stable.

Parameters:
numNeuron, `numNeuronLayer4 (10), number of neurons in the output layer.
dataWidth, `dataWidth (16), bit width of one neuron output.
countWidth, 16, width of the emitted-frame counter.

Ports:
i_clk  in  1  clock; all logic on the rising edge.
i_rst  in  1  reset; synchronous, active-high.
i_neuron_data  in  numNeuron*dataWidth  neuron n output at [n*dataWidth +: dataWidth].
i_neuron_valid  in  numNeuron  bit n is a 1-cycle strobe qualifying neuron n's slice.
o_data  out  numNeuron*dataWidth  packed completed frame, same slice layout as the input.
o_data_valid  out  1  1-cycle pulse when o_data is updated.
o_busy  out  1  high while the frame is partially captured (capture mask non-zero).
o_overrun  out  1  sticky error: a neuron strobed twice within one frame.
o_frame_count  out  countWidth  number of frames emitted; wraps modulo 2^countWidth.

Behaviour:
- State
  - capture mask: numNeuron bits.
  - capture buffer: numNeuron*dataWidth bits.
  - output register: o_data.
- Reset (i_rst=1 at an edge)
  - mask=0, buffer=0, o_data=0, o_data_valid=0, o_overrun=0, o_frame_count=0.
  - A partial frame is discarded. Strobes in the reset cycle are ignored.
- Capture, per cycle, for each n
  - i_neuron_valid[n]=1 and mask[n]=0: buffer slice n <= data slice n; mask[n] <= 1.
  - i_neuron_valid[n]=1 and mask[n]=1: o_overrun <= 1. Slice n is NOT overwritten (first value wins).
  - Any number of bits may be strobed in the same cycle.
- Completion
  - Condition: (mask | accepted strobes) == all ones in cycle t.
  - At edge t+1:
    - o_data <= buffer merged with the same-cycle captures.
    - o_data_valid <= 1 for exactly one cycle.
    - mask <= 0.
    - o_frame_count <= o_frame_count+1.
  - Latency: 1 cycle from the last-arriving strobe to the pulse.
- Back-to-back frames
  - Strobes in cycle t+1 (the pulse cycle) begin the next frame. No dead cycle.
  - o_data holds its value until the next completion, independent of capture activity.
- Duplicate strobe in the completing cycle: a strobe for an already-set mask bit still flags overrun and does not carry into the next frame.
- Default: o_data_valid is 0 every cycle in which it is not explicitly pulsed.
- o_busy is combinational from the mask (|mask). It is 0 in the cycle after completion unless new strobes arrived in the completion cycle.
- o_overrun is cleared only by i_rst.
- Frame spacing
  - max_finder needs numNeuron+1 cycles per frame.
  - The system guarantees completions are at least numNeuron+2 cycles apart.
  - This block does not enforce or flag the spacing.
- Data is treated as opaque bits; no arithmetic on data.

Decomposition:
- Shared package holds:
  - NUM_NEURON and DATA_WIDTH, derived from the global defines.
  - a neuron word typedef, logic [dataWidth-1:0].
  - a frame typedef, an array of numNeuron words.
- Sub-module collector_slot, instantiated numNeuron times via generate:
  - holds one buffer word and its mask bit.
  - outputs captured, word and dup_strobe.
  - has a clear input driven on completion.
- Top level does the AND-reduce, the output register, the counter and the overrun OR.

Test Plan:
1. All 10 valids in cycle 5, slice n = n*3 -> o_data_valid high only in cycle 6; slice n = n*3; o_frame_count=1; o_busy never high.
2. One strobe per cycle, neuron 9 down to 0, over cycles 10..19 -> o_busy high cycles 11..19; single pulse in cycle 20; all slices correct.
3. Neuron 4 strobed with 0x0011, later with 0x0022, then the remaining 9 strobed -> o_overrun=1 and stays 1; frame slice 4=0x0011; one pulse.
4. Frame A completes at t; frame B (all valids, slice n=0x100+n) at t+1 -> pulses at t+1 and t+2; o_data holds A at t+1, B from t+2.
5. 5 neurons captured, i_rst pulsed 1 cycle, then all 10 strobed -> exactly one pulse; o_frame_count=1; o_overrun=0; data from post-reset strobes only.
6. countWidth=4, 16 complete frames -> o_frame_count reads 15 then wraps to 0; every frame pulses once.
